// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller between EX/MEM and MEM/WB.
// Turns a load/store into a req/ack transaction on a multi-cycle data memory:
// byte-lane steering on stores, lane extraction plus sign/zero extension on
// loads. The pipeline is stalled until the access completes or times out.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds the misalign output and
// traps misaligned accesses instead of force-aligning them).
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        stall,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             signed_q;

  logic             accept;
  logic             misaligned_c;
  logic             trap_c;
  logic             timeout;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  assign accept       = valid_in & (MemRead | MemWrite);
  assign misaligned_c = ((MemSize == 2'b01) & ALUResult[0]) |
                        (MemSize[1] & (|ALUResult[1:0]));
  assign trap_c       = TRAP_EN & misaligned_c;
  assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Store lane steering from the incoming EX/MEM fields.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData;
    case (MemSize)
      2'b00: begin
        be_c    = 4'b0001 << ALUResult[1:0];
        wdata_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_c    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction using the offset/size captured at accept time.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; req is decoded from state so reset drops it at once.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    ready    = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = trap_c ? DONE : WAIT;
        end else begin
          ready = valid_in;
        end
      end
      WAIT: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack || timeout) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture the request at accept, collect the load result or time out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ReadData   <= '0;
      bus_err    <= 1'b0;
      cnt_q      <= '0;
      off_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          bus_err <= 1'b0;
          if (accept && !trap_c) begin
            dmem_we    <= MemWrite;
            dmem_addr  <= {ALUResult[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            off_q      <= ALUResult[1:0];
            size_q     <= MemSize;
            signed_q   <= MemSigned;
          end else if (accept) begin
            ReadData <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            if (!dmem_we) ReadData <= ld_ext;
          end else if (timeout) begin
            bus_err  <= 1'b1;
            ReadData <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          bus_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;

  // Remember that the access just accepted was trapped; shown only in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                mis_q <= 1'b0;
    else if (state_q == IDLE)  mis_q <= accept & misaligned_c;
    else if (state_q == DONE)  mis_q <= 1'b0;
  end

  assign misalign = (state_q == DONE) & mis_q;
`endif

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller between the EX/MEM register and the MEM/WB register.
- Turns a load/store into a req/ack transaction on a multi-cycle data memory: byte-lane steering, load extraction and sign/zero extension.
- Stalls the pipeline until the access completes, then drives ReadData and ready into the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT without dmem_ack before bus error (≥1).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  valid instruction present in MEM stage.
- MemRead  in  1  load.
- MemWrite  in  1  store; has priority if both are set.
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MemSigned  in  1  sign-extend loads when 1.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, right-aligned.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address; ALUResult with [1:0] forced to 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-steered store data.
- dmem_rdata  in  32  read word.
- dmem_ack  in  1  transaction complete; one-cycle pulse.
- ReadData  out  32  extended load result to MEM/WB.
- ready  out  1  stage result valid this cycle.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (async, reset=0): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, ReadData=0, bus_err=0, counter=0.
- An asserted reset mid-WAIT drops dmem_req immediately.
- IDLE:
  - If valid_in & (MemRead|MemWrite): register addr/we/be/wdata/size/signed, go to WAIT; stall=1, ready=0 in this cycle.
  - Otherwise: stall=0, ready=valid_in, no memory activity.
- WAIT:
  - dmem_req=1; addr/we/be/wdata are stable until ack; stall=1, ready=0; counter increments each cycle.
  - On dmem_ack: loads capture the extracted lane into ReadData, stores leave ReadData unchanged; drop req; go to DONE.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop req, bus_err=1 for one cycle, ReadData=0, go to DONE.
- DONE: ready=1, stall=0 for exactly one cycle, counter cleared, then IDLE. The EX/MEM advance and the MEM/WB capture happen on this edge.
- Latency: if ack arrives k cycles after req rises, ready rises k+1 cycles after the access is accepted. Minimum 3 cycles per memory op (accept, WAIT+ack, DONE).
- Store lanes:
  - Byte: be = 1 << addr[1:0]; wdata = byte replicated ×4.
  - Half: be = addr[1] ? 1100 : 0011; wdata = half replicated ×2.
  - Word: be = 1111.
- Load extraction:
  - Byte: select by addr[1:0]. Half: select by addr[1].
  - Extend to 32 bits with sign (MemSigned=1) or zeros.
- dmem_ack outside WAIT is ignored. dmem_rdata is sampled only on ack.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0), without the optional feature: low bits are ignored; the access is performed as if aligned.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misalign (1 bit).
  - A misaligned access in IDLE issues no request and goes straight to DONE.
  - In DONE: misalign=1 for one cycle, ReadData=0, ready=1; stall is 1 only in the accept cycle.
- When undefined: no misalign port; force-align behaviour as above.

Test Plan:
- LW at 0x0000_0010, ack after 2 WAIT cycles, rdata=0xDEADBEEF -> req with addr 0x10, be=1111, we=0; stall high 3 cycles; ready=1 in DONE; ReadData=0xDEADBEEF.
- LB signed at 0x13, rdata=0x80FF_0000 -> ReadData=0xFFFF_FF80; LBU same address -> 0x0000_0080; LHU at 0x12 -> 0x0000_80FF.
- SB 0xA5 at 0x21 -> dmem_we=1, be=0010, wdata=0xA5A5_A5A5, ReadData unchanged; SH 0x1234 at 0x22 -> be=1100, wdata=0x1234_1234.
- No ack for TIMEOUT_CYCLES=16 -> req drops after 16 WAIT cycles, bus_err pulses once, ReadData=0, ready=1 next cycle.
- Drive reset=0 mid-WAIT -> dmem_req=0 asynchronously, state IDLE, ReadData=0; a stray ack after release -> ignored.
- Non-memory valid_in=1 -> ready=1 same cycle, stall=0, no req. With MEM_MISALIGN_TRAP_EN, LW at 0x02 -> no req, misalign=1 pulse, ReadData=0.
